pe_act_queue: RTL and testbench
===============================

PE_ACT_QUEUE -- requirements
Module: pe_act_queue

Interface
Parameters:
REQ-001 The block SHALL have parameter PE_IDX, default 0, meaning PE index; it is used only for debug tagging.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries; DEPTH SHALL be a power of two, at least 2.
REQ-003 The block SHALL have parameter ENTRY_WIDTH, default `PEQueueBus` width, meaning packed {in_act_idx, in_act_value} entry width.

Ports:
REQ-004 The block SHALL have port clk, input, width 1: system clock.
REQ-005 The block SHALL have port rst, input, width 1: system reset, asynchronous, active-high.
REQ-006 The block SHALL have port push_act, input, width 1: network interface presents a received activation.
REQ-007 The block SHALL have port act_in, input, width ENTRY_WIDTH: received activation entry.
REQ-008 The block SHALL have port queue_full, output, width 1: no free entry.
REQ-009 The block SHALL have port queue_empty, output, width 1: no valid entry.
REQ-010 The block SHALL have port act_out, output, width ENTRY_WIDTH: head entry, first-word-fall-through.
REQ-011 The block SHALL have port pop_act, input, width 1: consumer removes the head entry.
REQ-012 The block SHALL have port out_act_clear, input, width 1: synchronous flush at layer start.
REQ-013 The block SHALL have port occupancy, output, width $clog2(DEPTH)+1: valid entry count.
REQ-014 The block SHALL have port overflow_err, output, width 1: sticky flag, set on a push while full.
REQ-015 The block SHALL have port underflow_err, output, width 1: sticky flag, set on a pop while empty.

Function
REQ-016 A push SHALL be accepted on a rising clk edge when push_act=1 and queue_full=0; act_in is written at the write pointer and the write pointer increments modulo DEPTH.
REQ-017 A pop SHALL be accepted on a rising clk edge when pop_act=1 and queue_empty=0; the read pointer increments modulo DEPTH.
REQ-018 act_out SHALL always show the entry at the read pointer, combinationally from storage; when queue_empty=1, act_out is don't-care and the bench SHALL NOT check it.
REQ-019 An entry SHALL take 1 cycle from push to visibility: after a push into an empty queue, queue_empty=0 and act_out=act_in on the next cycle.
REQ-020 A simultaneous accepted push and pop SHALL leave occupancy unchanged; when empty, only the push is accepted; when full, only the pop is accepted and the push is dropped.
REQ-021 queue_full and queue_empty SHALL be registered-state derived: full = (occupancy==DEPTH); empty = (occupancy==0).
REQ-022 Pointers SHALL be $clog2(DEPTH)+1 bits, with the MSB used as a wrap bit; full/empty SHALL be consistent with occupancy at every cycle.
REQ-023 A push with queue_full=1 SHALL be dropped, SHALL leave storage and pointers unchanged, and SHALL set overflow_err.
REQ-024 A pop with queue_empty=1 SHALL be ignored and SHALL set underflow_err.
REQ-025 out_act_clear=1 SHALL reset both pointers and occupancy to 0 on the next edge, SHALL take priority over push and pop in the same cycle, and SHALL clear both error flags.
REQ-026 Storage contents SHALL NOT be reset; only pointers, occupancy and flags are.

Reset
REQ-027 On rst=1, asynchronously, the block SHALL set pointers to 0, occupancy to 0, queue_empty to 1, queue_full to 0, overflow_err to 0 and underflow_err to 0.
REQ-028 A reset asserted mid-operation SHALL discard all queued entries; the first push after deassertion SHALL appear as the first entry.

Structure
REQ-029 The shared header pe.vh SHALL hold `PEQueueBus`, `PeAddrBus`, `PeDataBus` and a new `PeQueueDepth` default.
REQ-030 Entry packing SHALL be {idx, value}, with idx in the MSBs, matching the consumer's unpacking.
REQ-031 The block SHALL instantiate one natural sub-module, pe_queue_ram: a DEPTH x ENTRY_WIDTH register array with 1 write port and 1 asynchronous read port.

Verification
REQ-032 Reset, then push 0x0003_00A5 -> next cycle queue_empty=0, act_out=0x0003_00A5, occupancy=1.
REQ-033 Push 8 entries with DEPTH=8 -> queue_full=1; a 9th push leaves occupancy=8 and sets overflow_err=1; pops return the 8 entries in order.
REQ-034 With 4 entries queued, apply push and pop for 10 cycles -> occupancy stays 4, outputs stay in FIFO order, and the pointers wrap without error.
REQ-035 Pop on an empty queue -> underflow_err=1 and occupancy stays 0; then out_act_clear -> both flags are 0.
REQ-036 With 5 entries queued, assert out_act_clear together with push -> next cycle occupancy=0 and queue_empty=1.
REQ-037 Assert rst asynchronously between clock edges with 3 entries queued -> queue_empty=1 immediately; after release, push 0x11 -> act_out=0x11.

Source files
------------

// File: rtl/pe_act_queue_pkg.sv
// -----------------------------------------------------------------------------
// pe_act_queue_pkg
// Shared PE definitions for the activation queue and its consumers.
//   PE_ADDR_W      : width of the activation index field
//   PE_DATA_W      : width of the activation value field
//   PE_QUEUE_BUS_W : packed queue entry width, {idx, value}
//   PE_QUEUE_DEPTH : default number of queue entries
// -----------------------------------------------------------------------------
package pe_act_queue_pkg;

    localparam int PE_ADDR_W      = 16;
    localparam int PE_DATA_W      = 16;
    localparam int PE_QUEUE_BUS_W = PE_ADDR_W + PE_DATA_W;
    localparam int PE_QUEUE_DEPTH = 8;

    // Index sits in the MSBs so the consumer can unpack with a plain cast.
    typedef struct packed {
        logic [PE_ADDR_W-1:0] idx;
        logic [PE_DATA_W-1:0] value;
    } pe_queue_entry_t;

endpackage

// File: rtl/pe_queue_ram.sv
// -----------------------------------------------------------------------------
// pe_queue_ram
// DEPTH x ENTRY_WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from storage
// -----------------------------------------------------------------------------
module pe_queue_ram
    import pe_act_queue_pkg::*;
#(
    parameter int DEPTH       = PE_QUEUE_DEPTH,
    parameter int ENTRY_WIDTH = PE_QUEUE_BUS_W,
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [ENTRY_WIDTH-1:0] wdata,
    input  logic [AW-1:0]          raddr,
    output logic [ENTRY_WIDTH-1:0] rdata
);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pe_act_queue.sv
// -----------------------------------------------------------------------------
// pe_act_queue
// First-word-fall-through activation queue between the network interface and
// a processing element.
//   clk, rst        : clock, asynchronous active-high reset
//   push_act/act_in : received activation {idx, value}
//   queue_full      : no free entry
//   queue_empty     : no valid entry
//   act_out         : head entry (don't-care while empty)
//   pop_act         : consumer removes the head entry
//   out_act_clear   : synchronous flush at layer start, clears error flags
//   occupancy       : number of valid entries
//   overflow_err    : sticky, push attempted while full
//   underflow_err   : sticky, pop attempted while empty
// -----------------------------------------------------------------------------
module pe_act_queue
    import pe_act_queue_pkg::*;
#(
    parameter int PE_IDX      = 0,
    parameter int DEPTH       = PE_QUEUE_DEPTH,
    parameter int ENTRY_WIDTH = PE_QUEUE_BUS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_act,
    input  logic [ENTRY_WIDTH-1:0]   act_in,
    output logic                     queue_full,
    output logic                     queue_empty,
    output logic [ENTRY_WIDTH-1:0]   act_out,
    input  logic                     pop_act,
    input  logic                     out_act_clear,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("pe_act_queue[%0d]: DEPTH=%0d must be a power of two >= 2", PE_IDX, DEPTH);
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [PW-1:0] occ;
    logic          push_ok;
    logic          pop_ok;

    // Pointers carry one extra wrap bit, so their difference is the exact
    // occupancy in 0..DEPTH without a separate counter.
    assign occ         = wr_ptr_q - rd_ptr_q;
    assign occupancy   = occ;
    assign queue_full  = (occ == PW'(DEPTH));
    assign queue_empty = (occ == '0);

    assign push_ok = push_act & ~queue_full;
    assign pop_ok  = pop_act & ~queue_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        if (out_act_clear) begin
            // Flush wins over any push/pop in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_act && queue_full) begin
                ovf_d = 1'b1;
            end
            if (pop_act && queue_empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

    pe_queue_ram #(
        .DEPTH       (DEPTH),
        .ENTRY_WIDTH (ENTRY_WIDTH),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok & ~out_act_clear),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (act_in),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (act_out)
    );

endmodule

// File: tb/tb_pe_act_queue.sv
// -----------------------------------------------------------------------------
// tb_pe_act_queue
// Scoreboard bench for pe_act_queue (DEPTH=8, 32-bit entries). Inputs change
// 2 time units after each rising edge; the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_pe_act_queue;

    localparam int DEPTH = 8;
    localparam int EW    = 32;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_act = 1'b0;
    logic [EW-1:0] act_in = '0;
    logic          pop_act = 1'b0;
    logic          out_act_clear = 1'b0;
    logic          queue_full;
    logic          queue_empty;
    logic [EW-1:0] act_out;
    logic [OW-1:0] occupancy;
    logic          overflow_err;
    logic          underflow_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain queue of expected entries plus counters/flags.
    logic [EW-1:0] exp_q[$];
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    always #5 clk = ~clk;

    pe_act_queue #(
        .PE_IDX      (3),
        .DEPTH       (DEPTH),
        .ENTRY_WIDTH (EW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_act      (push_act),
        .act_in        (act_in),
        .queue_full    (queue_full),
        .queue_empty   (queue_empty),
        .act_out       (act_out),
        .pop_act       (pop_act),
        .out_act_clear (out_act_clear),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each edge, from the queue's rules rather than pointers.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (out_act_clear) begin
            exp_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            bit acc_push;
            bit acc_pop;
            acc_push = push_act && (m_cnt < DEPTH);
            acc_pop  = pop_act && (m_cnt > 0);
            if (push_act && m_cnt == DEPTH) m_ovf = 1'b1;
            if (pop_act && m_cnt == 0)      m_unf = 1'b1;
            if (acc_push) exp_q.push_back(act_in);
            m_cnt = m_cnt + int'(acc_push) - int'(acc_pop);
        end
    end

    // Monitor: status every cycle, head entry whenever non-empty, and the
    // scoreboard entry is consumed when the coming pop will be accepted.
    always @(negedge clk) begin
        if (!rst) begin
            check("occupancy", 64'(occupancy), 64'(m_cnt));
            check("queue_empty", 64'(queue_empty), 64'(m_cnt == 0));
            check("queue_full", 64'(queue_full), 64'(m_cnt == DEPTH));
            check("overflow_err", 64'(overflow_err), 64'(m_ovf));
            check("underflow_err", 64'(underflow_err), 64'(m_unf));
            if (m_cnt > 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard: no expected entry, act_out 0x%0h", act_out);
                end else begin
                    check("act_out_head", 64'(act_out), 64'(exp_q[0]));
                    if (pop_act && !out_act_clear) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Apply one cycle of stimulus, return 2 units after the edge.
    task automatic drive(input bit p, input bit q, input bit c, input logic [EW-1:0] d);
        push_act      = p;
        pop_act       = q;
        out_act_clear = c;
        act_in        = d;
        @(posedge clk);
        #2;
        push_act      = 1'b0;
        pop_act       = 1'b0;
        out_act_clear = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("rst_empty", 64'(queue_empty), 64'd1);
        check("rst_full", 64'(queue_full), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_ovf", 64'(overflow_err), 64'd0);
        check("rst_unf", 64'(underflow_err), 64'd0);
        rst = 1'b0;
        drive(0, 0, 0, '0);

        // First push becomes visible one cycle later.
        drive(1, 0, 0, 32'h0003_00A5);
        check("first_empty", 64'(queue_empty), 64'd0);
        check("first_act_out", 64'(act_out), 64'h0003_00A5);
        check("first_occ", 64'(occupancy), 64'd1);
        drive(0, 0, 1, '0);

        // Fill, overflow, drain in order.
        for (int i = 0; i < DEPTH; i++) drive(1, 0, 0, 32'h0100_0000 + 32'(i));
        check("fill_full", 64'(queue_full), 64'd1);
        drive(1, 0, 0, 32'hDEAD_BEEF);
        check("ovf_occ", 64'(occupancy), 64'd8);
        check("ovf_flag", 64'(overflow_err), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 64'(act_out), 64'(32'h0100_0000 + 32'(i)));
            drive(0, 1, 0, '0);
        end
        check("drain_empty", 64'(queue_empty), 64'd1);
        drive(0, 0, 1, '0);

        // Steady state push+pop with pointer wrap.
        for (int i = 0; i < 4; i++) drive(1, 0, 0, $urandom);
        for (int i = 0; i < 10; i++) drive(1, 1, 0, $urandom);
        check("steady_occ", 64'(occupancy), 64'd4);
        check("steady_ovf", 64'(overflow_err), 64'd0);
        drive(0, 0, 1, '0);

        // Underflow then clear.
        drive(0, 1, 0, '0);
        check("unf_flag", 64'(underflow_err), 64'd1);
        check("unf_occ", 64'(occupancy), 64'd0);
        drive(0, 0, 1, '0);
        check("clr_unf", 64'(underflow_err), 64'd0);
        check("clr_ovf", 64'(overflow_err), 64'd0);

        // Clear has priority over a simultaneous push.
        for (int i = 0; i < 5; i++) drive(1, 0, 0, $urandom);
        drive(1, 0, 1, 32'h5555_AAAA);
        check("clrpush_occ", 64'(occupancy), 64'd0);
        check("clrpush_empty", 64'(queue_empty), 64'd1);

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) drive(1, 0, 0, $urandom);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_empty", 64'(queue_empty), 64'd1);
        check("async_rst_occ", 64'(occupancy), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        drive(1, 0, 0, 32'h0000_0011);
        check("post_rst_act_out", 64'(act_out), 64'h11);
        check("post_rst_occ", 64'(occupancy), 64'd1);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                  $urandom_range(0, 99) < 3, $urandom);
        end
        repeat (2) drive(0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
